if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, the next-PC select and the IF/ID pipeline register.
- Downstream it feeds the ID stage, where the instruction decoder consumes IFID_Instruction and returns PCSrc.
- Takes redirects from ID (j/jal/jr/jalr) and from EX (taken beq), and stall/flush from the hazard unit.
- Instruction memory is combinational read (address and data in the same cycle).

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
NOP_INSTR  32'h0000_0000  bubble instruction (sll $0,$0,0) written into IF/ID on flush or reset

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
Imem_Addr  output  32  current PC to instruction memory
Imem_Data  input  32  instruction at Imem_Addr (combinational)
ID_PCSrc  input  2  from ID decoder: 00 seq, 01 branch (ignored here), 10 j/jal, 11 jr/jalr
ID_JrTarget  input  32  forwarded rs value for jr/jalr
EX_BranchTaken  input  1  beq resolved taken in EX
EX_BranchTarget  input  32  branch target computed in EX
Stall  input  1  load-use stall from hazard unit; holds PC and IF/ID
IFID_Instruction  output  32  registered instruction
IFID_PC_plus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  1 = real instruction, 0 = bubble
Flush_ID  output  1  combinational: IF/ID is being flushed this cycle (informational for the hazard unit)

Behaviour:
- Reset (reset==0, asynchronous): PC=RESET_PC, IFID_Instruction=NOP_INSTR, IFID_PC_plus4=0, IFID_Valid=0. First fetch occurs at RESET_PC on the first rising edge after deassertion. Reset asserted mid-operation discards everything in flight.
- Imem_Addr = PC (combinational). PC_plus4 = PC + 32'd4, modulo 2^32; wraps from 32'hFFFF_FFFC to 0 with no flag.
- Jump target = {IFID_PC_plus4[31:28], IFID_Instruction[25:0], 2'b00}, computed internally from the IF/ID outputs.
- Next-state priority, evaluated each rising edge, first match wins:
  1. EX_BranchTaken=1: PC <= EX_BranchTarget; IF/ID <= bubble. Overrides Stall and any ID redirect, because the branch is older.
  2. Stall=1: PC and IF/ID hold. An ID redirect is deferred; ID_PCSrc is re-presented next cycle because the ID instruction is held.
  3. ID_PCSrc==2'b10 and IFID_Valid: PC <= jump target; IF/ID <= bubble.
  4. ID_PCSrc==2'b11 and IFID_Valid: PC <= ID_JrTarget; IF/ID <= bubble.
  5. Otherwise: PC <= PC_plus4; IF/ID <= {Imem_Data, PC_plus4, Valid=1}.
- Bubble = {NOP_INSTR, PC_plus4 of the discarded fetch, Valid=0}.
- ID_PCSrc==2'b01 and 2'b00 both select the sequential path; branches are resolved only in EX.
- ID_PCSrc is ignored when IFID_Valid=0, so a bubble can never redirect.
- Flush_ID = EX_BranchTaken | (!Stall & IFID_Valid & ID_PCSrc[1]).
- Redirect penalty: a taken branch costs 2 bubbles (the ID-side bubble is inserted by the ID/EX register). A jump costs 1 bubble.
- A target address that is not word-aligned is loaded unchanged; there is no exception logic in this block.

Decomposition:
- Shared package/header: PCSrc encodings (PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_J=2'b10, PCSRC_JR=2'b11), RESET_PC and NOP_INSTR.
- PCSrc constants are used identically by the decoder and by this block.
- One sub-module: ifid_reg.
  - Contents: the IF/ID register with hold (stall) and clear-to-bubble (flush) controls, plus async active-low reset.
  - if_stage contains the PC register, adder, next-PC mux and priority logic, and instantiates ifid_reg.

Test Plan:
- Reset then free-run with Imem returning addr-tagged words -> Imem_Addr sequence 0,4,8,12; IFID_PC_plus4 lags one cycle (4,8,12); IFID_Valid rises on the first edge.
- Stall=1 for 2 cycles at PC=0x10 -> PC stays 0x10 and IF/ID holds the instruction from 0x0C; both resume at 0x14 when Stall drops.
- IFID_Instruction=j 0x0000100 (0x08000100), IFID_PC_plus4=0x0000_0020 -> next PC=0x0000_0400, one bubble (Valid=0, instr=0), Flush_ID=1 for that cycle.
- EX_BranchTaken=1 with target 0x40, Stall=1 and ID_PCSrc=2'b11 in the same cycle -> PC=0x40, IF/ID bubble; the jr is ignored.
- PC=32'hFFFF_FFFC sequential -> next PC=0, IFID_PC_plus4=0.
- Async reset pulse mid-cycle during a jump redirect -> outputs return to reset values immediately, before the next clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: PCSrc encodings used by both the ID decoder
// and the fetch stage, the reset/bubble constants and the jump-target helper.
package if_stage_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  // Source of the next PC, listed oldest-instruction-first.
  typedef enum logic [2:0] {
    SEL_BRANCH,
    SEL_STALL,
    SEL_JUMP,
    SEL_JR,
    SEL_SEQ
  } nextSel_t;

  function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                             input logic [31:0] instr);
    return {pcPlus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: hold on stall, clear to a bubble on flush.
// A bubble keeps the PC+4 of the fetch it discarded.
module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] fetchInstr,
  input  logic [31:0] fetchPcPlus4,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        valid
);

  import if_stage_pkg::*;

  // Flush wins over hold: a taken branch squashes even a stalled slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= NOP_INSTR;
      pcPlus4     <= 32'h0000_0000;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      pcPlus4     <= fetchPcPlus4;
      valid       <= 1'b0;
    end else if (!hold) begin
      instruction <= fetchInstr;
      pcPlus4     <= fetchPcPlus4;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority select and the
// IF/ID register. Instruction memory is read combinationally at the PC.
module if_stage #(
  parameter logic [31:0] RESET_PC  = if_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  input  logic [1:0]  ID_PCSrc,
  input  logic [31:0] ID_JrTarget,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchTarget,
  input  logic        Stall,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC_plus4,
  output logic        IFID_Valid,
  output logic        Flush_ID
);

  import if_stage_pkg::*;

  logic [31:0] pcReg;
  logic [31:0] pcNext;
  logic [31:0] pcPlus4;
  logic [31:0] jumpAddr;
  nextSel_t    nextSel;
  logic        flushNow;

  assign Imem_Addr = pcReg;
  assign pcPlus4   = pcReg + 32'd4;
  assign jumpAddr  = jumpTarget(IFID_PC_plus4, IFID_Instruction);

  // The EX branch is older than anything in ID, so it beats stall and jumps.
  // Redirects from a bubble are ignored; PCSRC_BR falls through to sequential.
  always_comb begin
    nextSel = SEL_SEQ;
    if (EX_BranchTaken)
      nextSel = SEL_BRANCH;
    else if (Stall)
      nextSel = SEL_STALL;
    else if (IFID_Valid && ID_PCSrc == PCSRC_J)
      nextSel = SEL_JUMP;
    else if (IFID_Valid && ID_PCSrc == PCSRC_JR)
      nextSel = SEL_JR;
  end

  always_comb begin
    pcNext = pcPlus4;
    case (nextSel)
      SEL_BRANCH: pcNext = EX_BranchTarget;
      SEL_STALL:  pcNext = pcReg;
      SEL_JUMP:   pcNext = jumpAddr;
      SEL_JR:     pcNext = ID_JrTarget;
      default:    pcNext = pcPlus4;
    endcase
  end

  assign flushNow = (nextSel == SEL_BRANCH) || (nextSel == SEL_JUMP) ||
                    (nextSel == SEL_JR);
  assign Flush_ID = flushNow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pcReg <= RESET_PC;
    else
      pcReg <= pcNext;
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) ifidReg (
    .clk         (clk),
    .reset       (reset),
    .hold        (Stall),
    .flush       (flushNow),
    .fetchInstr  (Imem_Data),
    .fetchPcPlus4(pcPlus4),
    .instruction (IFID_Instruction),
    .pcPlus4     (IFID_PC_plus4),
    .valid       (IFID_Valid)
  );

endmodule
